// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and defaults for the SRAM access arbiter
package sram_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_WHOLD,
    S_READ,
    S_RDONE
  } state_e;

  typedef enum logic {
    GRANT_WR,
    GRANT_RD
  } grant_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_pad_io.sv
// rtl/sram_pad_io.sv - registered SRAM strobes/address and the DQ tristate buffer
module sram_pad_io #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we_n_d,
  input  logic              i_oe_n_d,
  input  logic              i_dq_oe_d,
  input  logic              i_addr_load,
  input  logic [ADDR_W-1:0] i_addr_d,
  input  logic              i_data_load,
  input  logic [DATA_W-1:0] i_data_d,
  output logic [DATA_W-1:0] o_dq_in,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N
);

  logic              we_n_q;
  logic              oe_n_q;
  logic              dq_oe_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] dout_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      addr_q  <= '0;
      dout_q  <= '0;
    end else begin
      we_n_q  <= i_we_n_d;
      oe_n_q  <= i_oe_n_d;
      dq_oe_q <= i_dq_oe_d;
      if (i_addr_load) addr_q <= i_addr_d;
      if (i_data_load) dout_q <= i_data_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dout_q : 'z;
  assign o_dq_in   = SRAM_DQ;
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;

endmodule

// File: rtl/sram_access_arbiter.sv
// rtl/sram_access_arbiter.sv - round-robin write/read arbiter and access sequencer for one async SRAM
module sram_access_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int WR_CYCLES = 1,
  parameter int RD_CYCLES = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_wr_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_ack,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  inout  wire  [DATA_W-1:0] SRAM_DQ,
  output logic              SRAM_WE_N,
  output logic              SRAM_OE_N,
  output logic              SRAM_CE_N,
  output logic              SRAM_UB_N,
  output logic              SRAM_LB_N
);

  localparam int CNT_W = $clog2(max_int(WR_CYCLES, RD_CYCLES)) + 1;

  state_e            state_q;
  grant_e            last_grant_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_ack_q;
  logic              rd_ack_q;
  logic [DATA_W-1:0] rd_data_q;

  logic              go_wr;
  logic              go_rd;
  logic              cnt_done;
  logic              we_n_d;
  logic              oe_n_d;
  logic              dq_oe_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dq_in;

  // Pad strobes are registered, so they are derived from the decision taken this cycle.
  always_comb begin
    go_wr    = (state_q == S_IDLE) && i_wr_req && (!i_rd_req || last_grant_q == GRANT_RD);
    go_rd    = (state_q == S_IDLE) && i_rd_req && !go_wr;
    cnt_done = (cnt_q == '0);
    we_n_d   = !(go_wr || (state_q == S_WRITE && !cnt_done));
    oe_n_d   = !(go_rd || (state_q == S_READ && !cnt_done));
    dq_oe_d  = go_wr || (state_q == S_WRITE);
    addr_d   = go_wr ? i_wr_addr : i_rd_addr;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= GRANT_RD;
      cnt_q        <= '0;
      wr_ack_q     <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_wr) begin
            state_q      <= S_WRITE;
            last_grant_q <= GRANT_WR;
            cnt_q        <= CNT_W'(WR_CYCLES - 1);
          end else if (go_rd) begin
            state_q      <= S_READ;
            last_grant_q <= GRANT_RD;
            cnt_q        <= CNT_W'(RD_CYCLES - 1);
          end
        end
        S_WRITE: begin
          if (cnt_done) begin
            state_q  <= S_WHOLD;
            wr_ack_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WHOLD: state_q <= S_IDLE;
        S_READ: begin
          if (cnt_done) begin
            state_q   <= S_RDONE;
            rd_ack_q  <= 1'b1;
            rd_data_q <= dq_in;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_RDONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  sram_pad_io #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_pad (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_we_n_d   (we_n_d),
    .i_oe_n_d   (oe_n_d),
    .i_dq_oe_d  (dq_oe_d),
    .i_addr_load(go_wr || go_rd),
    .i_addr_d   (addr_d),
    .i_data_load(go_wr),
    .i_data_d   (i_wr_data),
    .o_dq_in    (dq_in),
    .SRAM_ADDR  (SRAM_ADDR),
    .SRAM_DQ    (SRAM_DQ),
    .SRAM_WE_N  (SRAM_WE_N),
    .SRAM_OE_N  (SRAM_OE_N)
  );

  assign o_wr_ack  = wr_ack_q;
  assign o_rd_ack  = rd_ack_q;
  assign o_rd_data = rd_data_q;
  assign o_busy    = (state_q != S_IDLE);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// tb/tb_sram_access_arbiter.sv - directed self-checking bench for sram_access_arbiter
module tb_sram_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // DUT A: default timing
  logic        wr_req_a = 0, rd_req_a = 0;
  logic [19:0] wr_addr_a = 0, rd_addr_a = 0;
  logic [15:0] wr_data_a = 0;
  logic        wr_ack_a, rd_ack_a, busy_a, we_n_a, oe_n_a, ce_n_a, ub_n_a, lb_n_a;
  logic [15:0] rd_data_a;
  logic [19:0] addr_a;
  wire  [15:0] dq_a;
  logic [15:0] mem_a [0:255];

  sram_access_arbiter dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req_a), .i_wr_addr(wr_addr_a), .i_wr_data(wr_data_a), .o_wr_ack(wr_ack_a),
    .i_rd_req(rd_req_a), .i_rd_addr(rd_addr_a), .o_rd_ack(rd_ack_a), .o_rd_data(rd_data_a),
    .o_busy(busy_a), .SRAM_ADDR(addr_a), .SRAM_DQ(dq_a),
    .SRAM_WE_N(we_n_a), .SRAM_OE_N(oe_n_a),
    .SRAM_CE_N(ce_n_a), .SRAM_UB_N(ub_n_a), .SRAM_LB_N(lb_n_a)
  );

  assign dq_a = !oe_n_a ? mem_a[addr_a[7:0]] : 'z;
  always @(posedge clk) if (!we_n_a) mem_a[addr_a[7:0]] <= dq_a;

  // DUT B: stretched strobes
  logic        wr_req_b = 0, rd_req_b = 0;
  logic [19:0] wr_addr_b = 0, rd_addr_b = 0;
  logic [15:0] wr_data_b = 0;
  logic        wr_ack_b, rd_ack_b, busy_b, we_n_b, oe_n_b, ce_n_b, ub_n_b, lb_n_b;
  logic [15:0] rd_data_b;
  logic [19:0] addr_b;
  wire  [15:0] dq_b;
  logic [15:0] mem_b [0:255];

  sram_access_arbiter #(.WR_CYCLES(3), .RD_CYCLES(2)) dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_wr_req(wr_req_b), .i_wr_addr(wr_addr_b), .i_wr_data(wr_data_b), .o_wr_ack(wr_ack_b),
    .i_rd_req(rd_req_b), .i_rd_addr(rd_addr_b), .o_rd_ack(rd_ack_b), .o_rd_data(rd_data_b),
    .o_busy(busy_b), .SRAM_ADDR(addr_b), .SRAM_DQ(dq_b),
    .SRAM_WE_N(we_n_b), .SRAM_OE_N(oe_n_b),
    .SRAM_CE_N(ce_n_b), .SRAM_UB_N(ub_n_b), .SRAM_LB_N(lb_n_b)
  );

  assign dq_b = !oe_n_b ? mem_b[addr_b[7:0]] : 'z;
  always @(posedge clk) if (!we_n_b) mem_b[addr_b[7:0]] <= dq_b;

  always @(negedge clk) begin
    check("excl_a", 32'(we_n_a | oe_n_a), 32'd1);
    check("excl_b", 32'(we_n_b | oe_n_b), 32'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    wr_req_a = 0; rd_req_a = 0;
    step();
    step();
    rst = 1'b0;
  endtask

  int order[$];
  logic prev_ack;

  initial begin
    do_reset();
    rst = 1'b1;
    step();
    check("rst_we_n",   32'(we_n_a), 32'd1);
    check("rst_oe_n",   32'(oe_n_a), 32'd1);
    check("rst_addr",   32'(addr_a), 32'd0);
    check("rst_dq_oe",  32'(dut_a.u_pad.dq_oe_q), 32'd0);
    check("rst_wr_ack", 32'(wr_ack_a), 32'd0);
    check("rst_rd_ack", 32'(rd_ack_a), 32'd0);
    check("rst_rd_data", 32'(rd_data_a), 32'd0);
    check("rst_busy",   32'(busy_a), 32'd0);
    check("tie_ce_ub_lb", 32'({ce_n_a, ub_n_a, lb_n_a}), 32'd0);
    rst = 1'b0;

    // single write
    wr_req_a = 1; wr_addr_a = 20'h00010; wr_data_a = 16'hBEEF;
    step();
    check("wr_c1_we_n", 32'(we_n_a), 32'd0);
    check("wr_c1_dq",   32'(dq_a), 32'hBEEF);
    check("wr_c1_addr", 32'(addr_a), 32'h10);
    check("wr_c1_ack",  32'(wr_ack_a), 32'd0);
    check("wr_c1_busy", 32'(busy_a), 32'd1);
    step();
    check("wr_c2_we_n",  32'(we_n_a), 32'd1);
    check("wr_c2_dq_oe", 32'(dut_a.u_pad.dq_oe_q), 32'd1);
    check("wr_c2_dq",    32'(dq_a), 32'hBEEF);
    check("wr_c2_ack",   32'(wr_ack_a), 32'd1);
    wr_req_a = 0;
    step();
    check("wr_c3_dq_oe", 32'(dut_a.u_pad.dq_oe_q), 32'd0);
    check("wr_c3_ack",   32'(wr_ack_a), 32'd0);
    check("wr_c3_busy",  32'(busy_a), 32'd0);
    check("wr_c3_addr_hold", 32'(addr_a), 32'h10);

    // single read
    rd_req_a = 1; rd_addr_a = 20'h00010;
    step();
    check("rd_c1_oe_n", 32'(oe_n_a), 32'd0);
    check("rd_c1_dq_oe", 32'(dut_a.u_pad.dq_oe_q), 32'd0);
    check("rd_c1_ack",  32'(rd_ack_a), 32'd0);
    step();
    check("rd_c2_ack",  32'(rd_ack_a), 32'd1);
    check("rd_c2_data", 32'(rd_data_a), 32'hBEEF);
    check("rd_c2_oe_n", 32'(oe_n_a), 32'd1);
    rd_req_a = 0;
    step();
    check("rd_c3_ack",  32'(rd_ack_a), 32'd0);
    check("rd_c3_hold", 32'(rd_data_a), 32'hBEEF);

    // simultaneous requests after reset: write first, then turnaround, then read
    do_reset();
    wr_req_a = 1; wr_addr_a = 20'h00020; wr_data_a = 16'h1234;
    rd_req_a = 1; rd_addr_a = 20'h00010;
    step();
    check("both_c1_we_n", 32'(we_n_a), 32'd0);
    check("both_c1_oe_n", 32'(oe_n_a), 32'd1);
    step();
    check("both_c2_wr_ack", 32'(wr_ack_a), 32'd1);
    wr_req_a = 0;
    step();
    check("both_c3_busy",  32'(busy_a), 32'd0);
    check("both_c3_dq_oe", 32'(dut_a.u_pad.dq_oe_q), 32'd0);
    check("both_c3_oe_n",  32'(oe_n_a), 32'd1);
    step();
    check("both_c4_oe_n", 32'(oe_n_a), 32'd0);
    check("both_c4_addr", 32'(addr_a), 32'h10);
    step();
    check("both_c5_rd_ack", 32'(rd_ack_a), 32'd1);
    check("both_c5_data",   32'(rd_data_a), 32'hBEEF);
    rd_req_a = 0;
    step();

    // round robin with both held
    do_reset();
    wr_req_a = 1; rd_req_a = 1;
    prev_ack = 0;
    for (int cyc = 0; cyc < 40 && order.size() < 4; cyc++) begin
      step();
      if (wr_ack_a) order.push_back(0);
      if (rd_ack_a) order.push_back(1);
      if (wr_ack_a || rd_ack_a) check("rr_pulse", 32'(prev_ack), 32'd0);
      prev_ack = wr_ack_a | rd_ack_a;
    end
    wr_req_a = 0; rd_req_a = 0;
    check("rr_count", 32'(order.size()), 32'd4);
    for (int k = 0; k < order.size(); k++)
      check($sformatf("rr_order%0d", k), 32'(order[k]), 32'(k % 2));
    step();
    step();

    // reset during write
    do_reset();
    wr_req_a = 1; wr_addr_a = 20'h00040; wr_data_a = 16'h5555;
    step();
    check("rstw_c1_we_n", 32'(we_n_a), 32'd0);
    rst = 1'b1; wr_req_a = 0;
    step();
    check("rstw_we_n",  32'(we_n_a), 32'd1);
    check("rstw_dq_oe", 32'(dut_a.u_pad.dq_oe_q), 32'd0);
    check("rstw_busy",  32'(busy_a), 32'd0);
    check("rstw_ack",   32'(wr_ack_a), 32'd0);
    rst = 1'b0;
    step();
    check("rstw_ack2",  32'(wr_ack_a), 32'd0);
    check("rstw_busy2", 32'(busy_a), 32'd0);

    // stretched timing on DUT B
    wr_req_b = 1; wr_addr_b = 20'h00033; wr_data_b = 16'hA5C3;
    for (int c = 1; c <= 5; c++) begin
      step();
      check($sformatf("b_wr_we_n_c%0d", c), 32'(we_n_b), 32'(c <= 3 ? 0 : 1));
      check($sformatf("b_wr_ack_c%0d", c), 32'(wr_ack_b), 32'(c == 4 ? 1 : 0));
      if (c == 4) wr_req_b = 0;
    end
    rd_req_b = 1; rd_addr_b = 20'h00033;
    for (int c = 1; c <= 4; c++) begin
      step();
      check($sformatf("b_rd_oe_n_c%0d", c), 32'(oe_n_b), 32'(c <= 2 ? 0 : 1));
      check($sformatf("b_rd_ack_c%0d", c), 32'(rd_ack_b), 32'(c == 3 ? 1 : 0));
      if (c == 3) begin
        check("b_rd_data", 32'(rd_data_b), 32'hA5C3);
        rd_req_b = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
